// File: rtl/priority_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// priority_mux_arbiter_if
//
// Purpose: bundles the producer-side and consumer-side handshake signals of
// priority_mux_arbiter into one interface.
//
// Signals:
//   mode      - 0 = fixed priority (ch0 highest), 1 = round-robin
//   in_data   - NUM_CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready (at most one bit set)
//   in_last   - per-channel end-of-packet flag (only with PRIORITY_MUX_LOCK_EN)
//   out_data  - registered selected data
//   out_sel   - registered index of the channel that supplied out_data
//   out_valid - registered output valid
//   out_ready - downstream ready
//
// Modports: master = producers/consumer environment, slave = the arbiter.
// Optional macro: PRIORITY_MUX_LOCK_EN adds in_last.
// ---------------------------------------------------------------------------
interface priority_mux_arbiter_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                    mode;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
`ifdef PRIORITY_MUX_LOCK_EN
    logic [NUM_CH-1:0]       in_last;
`endif
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
`ifdef PRIORITY_MUX_LOCK_EN
        output in_last,
`endif
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
`ifdef PRIORITY_MUX_LOCK_EN
        input  in_last,
`endif
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/priority_mux_arbiter.sv
// ---------------------------------------------------------------------------
// priority_mux_arbiter
//
// Purpose: arbitrates NUM_CH valid/ready producer channels onto a single
// registered output stage, in fixed-priority or round-robin mode.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   bus        - priority_mux_arbiter_if.slave (channels in, one channel out)
//   dbg_rr_ptr - current round-robin pointer (observation only)
//   dbg_locked - packet lock held (only with PRIORITY_MUX_LOCK_EN)
//
// Handshake: a word moves on any valid/ready pair when both are 1 at a rising
// clk edge. Producers hold valid and data stable until that edge; in_ready
// may depend combinationally on in_valid, out_valid and out_ready.
//
// Optional macro: PRIORITY_MUX_LOCK_EN adds packet locking via in_last. Once a
// non-last beat is taken from a channel, only that channel is granted until
// its last beat is taken.
// ---------------------------------------------------------------------------
module priority_mux_arbiter #(
    parameter  int WIDTH  = 4,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    priority_mux_arbiter_if.slave bus,
    output logic [SEL_W-1:0] dbg_rr_ptr
`ifdef PRIORITY_MUX_LOCK_EN
    ,
    output logic             dbg_locked
`endif
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] srch_grant;
    logic             srch_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [SEL_W-1:0] ptr_next;

    // Search order: from ch0 in fixed mode, from rr_ptr with wrap in
    // round-robin mode. The first valid channel in that order wins.
    always_comb begin
        int idx;
        srch_grant = '0;
        srch_vld   = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.mode) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
            end else begin
                idx = k;
            end
            if (!srch_vld && bus.in_valid[idx[SEL_W-1:0]]) begin
                srch_vld   = 1'b1;
                srch_grant = idx[SEL_W-1:0];
            end
        end
    end

`ifdef PRIORITY_MUX_LOCK_EN
    typedef enum logic {LK_OPEN, LK_HELD} lock_state_t;
    lock_state_t      lock_state;
    logic [SEL_W-1:0] lock_ch;

    // While a packet is open only its owner may be granted; when the owner
    // has nothing valid there is no grant at all.
    assign grant      = (lock_state == LK_HELD) ? lock_ch : srch_grant;
    assign grant_vld  = (lock_state == LK_HELD) ? bus.in_valid[lock_ch] : srch_vld;
    assign dbg_locked = (lock_state == LK_HELD);
`else
    assign grant     = srch_grant;
    assign grant_vld = srch_vld;
`endif

    // The output register can take a word when empty or being drained now.
    assign load_en  = !bus.out_valid || bus.out_ready;
    assign xfer     = rst_n && load_en && grant_vld;
    assign ptr_next = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[grant] = 1'b1;
    end

    assign dbg_rr_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rr_ptr        <= '0;
`ifdef PRIORITY_MUX_LOCK_EN
            lock_state    <= LK_OPEN;
            lock_ch       <= '0;
`endif
        end else if (xfer) begin
            // A pop and a new load in the same cycle simply overwrite the
            // register, so there is no bubble.
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
            bus.out_sel   <= grant;
`ifdef PRIORITY_MUX_LOCK_EN
            if (bus.in_last[grant]) begin
                lock_state <= LK_OPEN;
                rr_ptr     <= ptr_next;
            end else begin
                // Pointer stays put mid-packet so fairness resumes after it.
                lock_state <= LK_HELD;
                lock_ch    <= grant;
            end
`else
            rr_ptr        <= ptr_next;
`endif
        end else if (bus.out_valid && bus.out_ready) begin
            // Drained with nothing new: data/sel keep their stale values.
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_priority_mux_arbiter.sv
`timescale 1ns/1ps
module tb_priority_mux_arbiter;
    localparam int WIDTH  = 4;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [SEL_W-1:0] dbg_rr_ptr;
`ifdef PRIORITY_MUX_LOCK_EN
    logic dbg_locked;
`endif

    priority_mux_arbiter_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

    priority_mux_arbiter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .dbg_rr_ptr (dbg_rr_ptr)
`ifdef PRIORITY_MUX_LOCK_EN
        ,
        .dbg_locked (dbg_locked)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] last;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [3:0] exp_data;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs[$];
    vec_t lock_vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic [3:0] v, input logic o,
                                input logic [3:0] last, input logic [3:0] er, input logic ov,
                                input logic [1:0] sel, input logic [3:0] d, input logic [1:0] p);
        vec_t t;
        t.rst = r; t.mode = m; t.valid = v; t.ordy = o; t.last = last;
        t.exp_ready = er; t.exp_ov = ov; t.exp_sel = sel; t.exp_data = d; t.exp_ptr = p;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic m, input logic [3:0] v, input logic o,
                         input logic [3:0] last);
        rst_n         = r;
        bus.mode      = m;
        bus.in_valid  = v;
        bus.out_ready = o;
`ifdef PRIORITY_MUX_LOCK_EN
        bus.in_last   = last;
`else
        if (last == 4'hx) rst_n = r;
`endif
    endtask

    task automatic apply_vec(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.rst, t.mode, t.valid, t.ordy, t.last);
        #1;
        check($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'(t.exp_ready));
        @(posedge clk);
        #1;
        check($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(t.exp_ov));
        check($sformatf("%s.out_sel", tag), 32'(bus.out_sel), 32'(t.exp_sel));
        check($sformatf("%s.out_data", tag), 32'(bus.out_data), 32'(t.exp_data));
        check($sformatf("%s.rr_ptr", tag), 32'(dbg_rr_ptr), 32'(t.exp_ptr));
    endtask

    // Reference grant: build the search order the rules describe, then take
    // the first requesting channel in that order.
    function automatic int pick(input logic m, input int ptr, input logic [3:0] v);
        int order[$];
        for (int k = 0; k < NUM_CH; k++) order.push_back(m ? (ptr + k) % NUM_CH : k);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic       m_valid;
        logic [3:0] m_data;
        int         m_sel;
        int         m_ptr;
        logic       pv[NUM_CH];
        logic [3:0] pd[NUM_CH];
        logic       cur_mode;
        logic       o;
        logic [3:0] v;
        logic [15:0] dv;
        logic       le;
        int         g;
        logic [3:0] er;
        logic [SEL_W+WIDTH-1:0] w;

        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.in_data   = 16'hC53A;   // ch3=C ch2=5 ch1=3 ch0=A
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
`ifdef PRIORITY_MUX_LOCK_EN
        bus.in_last   = 4'hF;
`endif

        //                 rst  mode valid  ordy last   ready  ov  sel  data  ptr
        vecs.push_back(mk(1'b0, 1'b0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 2'd0)); // reset
        vecs.push_back(mk(1'b0, 1'b0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 4'h1, 1'b1, 2'd0, 4'hA, 2'd1)); // first grant ch0
        vecs.push_back(mk(1'b1, 1'b0, 4'hA, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 4'h3, 2'd2)); // fixed prio
        vecs.push_back(mk(1'b1, 1'b0, 4'hA, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 4'h3, 2'd2)); // ch3 starved
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 4'h4, 1'b1, 2'd2, 4'h5, 2'd3)); // round-robin
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 4'h8, 1'b1, 2'd3, 4'hC, 2'd0));
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 4'h1, 1'b1, 2'd0, 4'hA, 2'd1));
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 4'h3, 2'd2));
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 4'hF, 4'h0, 1'b1, 2'd1, 4'h3, 2'd2)); // backpressure
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 4'hF, 4'h0, 1'b1, 2'd1, 4'h3, 2'd2));
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 4'hF, 4'h0, 1'b1, 2'd1, 4'h3, 2'd2));
        vecs.push_back(mk(1'b1, 1'b1, 4'h4, 1'b1, 4'hF, 4'h4, 1'b1, 2'd2, 4'h5, 2'd3)); // pop+load
        vecs.push_back(mk(1'b1, 1'b1, 4'h1, 1'b1, 4'hF, 4'h1, 1'b1, 2'd0, 4'hA, 2'd1)); // wrap
        vecs.push_back(mk(1'b1, 1'b1, 4'h0, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 4'hA, 2'd1)); // drain
        vecs.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 4'hA, 2'd1)); // idle
        vecs.push_back(mk(1'b1, 1'b0, 4'h8, 1'b0, 4'hF, 4'h8, 1'b1, 2'd3, 4'hC, 2'd0)); // load when empty
        vecs.push_back(mk(1'b1, 1'b0, 4'h6, 1'b0, 4'hF, 4'h0, 1'b1, 2'd3, 4'hC, 2'd0)); // stalled
        vecs.push_back(mk(1'b0, 1'b0, 4'h6, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 2'd0)); // reset mid-word
        vecs.push_back(mk(1'b1, 1'b1, 4'h6, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 4'h3, 2'd2));

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // ---------------- randomized phase against reference model ----------------
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hF);
        @(posedge clk);
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        cur_mode = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        exp_q.delete();

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pd[i] = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
            o = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                v[i] = pv[i];
                dv[i*4 +: 4] = pd[i];
            end
            bus.in_data = dv;
            drive(1'b1, cur_mode, v, o, 4'hF);
            #1;
            le = !m_valid || o;
            g  = pick(cur_mode, m_ptr, v);
            er = (le && g >= 0) ? 4'(1 << g) : 4'h0;
            check("rnd.in_ready", 32'(bus.in_ready), 32'(er));
            if (m_valid && o) begin
                check("rnd.sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("rnd.sb_word", 32'({bus.out_sel, bus.out_data}), 32'(w));
                end
            end
            @(posedge clk);
            #1;
            if (le && g >= 0) begin
                m_valid = 1'b1;
                m_data  = pd[g];
                m_sel   = g;
                m_ptr   = (g + 1) % NUM_CH;
                pv[g]   = 1'b0;
                exp_q.push_back({2'(g), pd[g]});
            end else if (m_valid && o) begin
                m_valid = 1'b0;
            end
            check("rnd.out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("rnd.rr_ptr", 32'(dbg_rr_ptr), 32'(m_ptr));
            if (m_valid) begin
                check("rnd.out_sel", 32'(bus.out_sel), 32'(m_sel));
                check("rnd.out_data", 32'(bus.out_data), 32'(m_data));
            end
        end
        check("rnd.sb_leftover", 32'(exp_q.size()), 32'(m_valid ? 1 : 0));

`ifdef PRIORITY_MUX_LOCK_EN
        // ---------------- packet lock sequence ----------------
        bus.in_data = 16'hC53A;
        //                      rst  mode valid  ordy last   ready  ov  sel  data  ptr
        lock_vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 2'd0));
        lock_vecs.push_back(mk(1'b1, 1'b0, 4'h4, 1'b1, 4'h0, 4'h4, 1'b1, 2'd2, 4'h5, 2'd0)); // beat 1
        lock_vecs.push_back(mk(1'b1, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd2, 4'h5, 2'd0)); // owner idle
        lock_vecs.push_back(mk(1'b1, 1'b0, 4'h5, 1'b1, 4'h0, 4'h4, 1'b1, 2'd2, 4'h5, 2'd0)); // beat 2
        lock_vecs.push_back(mk(1'b1, 1'b0, 4'h5, 1'b1, 4'h4, 4'h4, 1'b1, 2'd2, 4'h5, 2'd3)); // last beat
        lock_vecs.push_back(mk(1'b1, 1'b0, 4'h1, 1'b1, 4'h0, 4'h1, 1'b1, 2'd0, 4'hA, 2'd1)); // released
        foreach (lock_vecs[i]) apply_vec(lock_vecs[i], $sformatf("lock%0d", i));
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_mux_arbiter.md
Name: priority_mux_arbiter

Overview:
- Parametrised successor to the team's 4:1 selector/encoder.
- Arbitrates NUM_CH valid/ready input channels of WIDTH bits onto one registered output.
- Two modes: fixed priority (lowest index wins) or round-robin.
- Sits between multiple producers and a single downstream consumer; one output register stage decouples timing.

Parameters:
- WIDTH, 4, data width per channel.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), width of the selected-channel index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = fixed priority (ch0 highest), 1 = round-robin.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit set.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Single clock domain; reset is synchronous, active-low on rst_n.
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is forced to all-zero while rst_n=0.
- Accept condition: load_en = !out_valid || out_ready. The output register loads only when load_en=1 and any in_valid is set.
- Grant (combinational):
  - mode=0: lowest-index set bit of in_valid.
  - mode=1: first set bit of in_valid searching from rr_ptr upward, wrapping NUM_CH-1 -> 0.
- in_ready[g] = load_en && in_valid[g] for the granted g only; all other in_ready bits are 0. A transfer on channel i is in_valid[i] && in_ready[i].
- On transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Round-robin pointer:
  - On a transfer, rr_ptr <= (g==NUM_CH-1) ? 0 : g+1, in both modes.
  - No transfer: rr_ptr holds.
  - The pointer is therefore fair immediately after a switch to mode=1.
- Output handshake:
  - out_valid && out_ready with no new grant: out_valid <= 0 next cycle; out_data and out_sel hold their stale values.
  - out_valid && !out_ready: out_data and out_sel are held stable and in_ready is all zero.
- Latency: transfer at edge N produces out_valid=1 with the data after edge N. Sustained throughput is 1 word/cycle while out_ready=1.
- Simultaneous downstream pop and new grant in the same cycle: the register is overwritten with the new word and out_valid stays 1 (no bubble).
- No in_valid set: no grant, in_ready=0, rr_ptr unchanged.
- mode changes take effect on the grant of the same cycle; no internal state is cleared.
- Reset asserted mid-transfer: the pending output word is discarded, out_valid=0 at the next edge, rr_ptr=0.
- Input protocol: once in_valid is asserted, in_data is stable until transfer. The block does not check this.

Optional Feature:
- Macro: PRIORITY_MUX_LOCK_EN.
- Defined:
  - Adds port in_last (input, NUM_CH): end-of-packet flag per channel.
  - After a transfer from channel g with in_last[g]=0, the arbiter locks to g. The grant is g only; other channels are masked even if higher priority, and rr_ptr does not advance.
  - The lock releases after the transfer with in_last[g]=1; rr_ptr then advances to g+1 with wrap.
  - A lock is held across cycles where in_valid[g]=0. During those cycles there is no grant.
  - Reset clears the lock.
- Undefined: port in_last is absent; every transfer is independently arbitrated as above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_sel=0, in_ready=0. After release, first grant is ch0.
- Fixed priority: mode=0, in_valid=4'b1010, data ch1=4'h3, ch3=4'hC, out_ready=1 -> out_data=4'h3, out_sel=1 after one edge. ch3 is starved while ch1 stays valid.
- Round-robin: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; no bubbles.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0. On out_ready=1 with in_valid=4'b0100, the next word comes from ch2 with no bubble.
- Wrap and sparse: mode=1, rr_ptr=3 (after a ch2 transfer), in_valid=4'b0001 -> ch0 granted, rr_ptr=1. Then in_valid=0 -> out_valid drops after the pop and rr_ptr holds at 1.
- Lock (PRIORITY_MUX_LOCK_EN): ch2 sends 3 beats with in_last=0,0,1 while ch0 valid in mode=0 -> out_sel=2,2,2, then 0.
